seq_tx: RTL and testbench

SEQ_TX -- requirements
Module: seq_tx

---
 rtl/seq_tx_if.sv | 23 ++
 rtl/seq_tx.sv | 102 ++++++++++
 tb/tb_seq_tx.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/seq_tx_if.sv
// rtl/seq_tx_if.sv - start/pattern request and serial output bundle for seq_tx
interface seq_tx_if #(
  parameter int PLEN = 4
);
  logic            start;
  logic [PLEN-1:0] pattern;
  logic [3:0]      reps;
  logic [1:0]      gap;
  logic            y;
  logic            valid;
  logic            busy;
  logic            done;

  modport master (
    output start, pattern, reps, gap,
    input  y, valid, busy, done
  );

  modport slave (
    input  start, pattern, reps, gap,
    output y, valid, busy, done
  );
endinterface

// File: rtl/seq_tx.sv
// rtl/seq_tx.sv - repeated serial pattern transmitter with idle gaps (Moore FSM)
module seq_tx #(
  parameter int PLEN = 4
) (
  input logic   clk,
  input logic   rst,
  seq_tx_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;

  localparam int             BW   = $clog2(PLEN);
  localparam logic [BW-1:0]  LAST = BW'(PLEN - 1);

  state_t          state, nxt;
  logic [PLEN-1:0] sreg;       // MSB is the bit on y this cycle
  logic [PLEN-1:0] pat_q;      // captured pattern, reloaded for each repetition
  logic [3:0]      reps_left;  // repetitions not yet finished, including the current one
  logic [1:0]      gap_q;
  logic [1:0]      gap_cnt;
  logic [BW-1:0]   bit_cnt;

  logic last_bit, last_rep, gap_end;
  assign last_bit = (bit_cnt == LAST);
  assign last_rep = (reps_left == 4'd1);
  assign gap_end  = (gap_cnt == 2'd1);

  // State register; reset drops straight to IDLE, aborting any burst without done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // Next-state decode; start is only looked at in IDLE so it is never queued
  always_comb begin
    nxt = state;
    case (state)
      IDLE:  if (bus.start) nxt = (bus.reps == 4'd0) ? DONE : SHIFT;
      SHIFT: if (last_bit) begin
               if (last_rep)           nxt = DONE;
               else if (gap_q == 2'd0) nxt = SHIFT;
               else                    nxt = GAP;
             end
      GAP:   if (gap_end) nxt = SHIFT;
      DONE:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Moore outputs decoded from registered state only
  always_comb begin
    bus.y     = 1'b0;
    bus.valid = 1'b0;
    bus.busy  = 1'b0;
    bus.done  = 1'b0;
    case (state)
      SHIFT: begin
        bus.y     = sreg[PLEN-1];
        bus.valid = 1'b1;
        bus.busy  = 1'b1;
      end
      GAP:  bus.busy = 1'b1;
      DONE: bus.done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: capture on accept, shift per bit, reload at the end of each repetition
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg      <= '0;
      pat_q     <= '0;
      reps_left <= '0;
      gap_q     <= '0;
      gap_cnt   <= '0;
      bit_cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          sreg      <= bus.pattern;
          pat_q     <= bus.pattern;
          reps_left <= bus.reps;
          gap_q     <= bus.gap;
          bit_cnt   <= '0;
        end
        SHIFT: if (last_bit) begin
          // Reload now so a zero-gap repetition follows with no bubble
          sreg      <= pat_q;
          bit_cnt   <= '0;
          reps_left <= reps_left - 4'd1;
          gap_cnt   <= gap_q;
        end else begin
          sreg    <= {sreg[PLEN-2:0], 1'b0};
          bit_cnt <= bit_cnt + BW'(1);
        end
        GAP: gap_cnt <= gap_cnt - 2'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_tx.sv
// tb/tb_seq_tx.sv - scoreboard bench for seq_tx with a timeline reference model
module tb_seq_tx;
  localparam int PLEN = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_tx_if #(.PLEN(PLEN)) bus ();
  seq_tx #(.PLEN(PLEN)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    bit is_done;
    int cyc;
    int val;   // bit value, or expected busy-cycle count for a done item
  } item_t;

  item_t q[$];
  item_t mon_it;
  int    cyc = 0;
  int    next_accept = 0;
  int    busy_cnt = 0;
  int    n_vec = 0;
  int    n_fail = 0;

  // Cycle n is the period that follows the n-th rising edge
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Reference timeline of a burst accepted at edge a
  function automatic void accept(int a, logic [PLEN-1:0] p, int r, int g);
    item_t it;
    int d;
    d = a;
    if (r > 0) begin
      for (int rep = 0; rep < r; rep++)
        for (int k = 0; k < PLEN; k++) begin
          it.is_done = 1'b0;
          it.cyc     = a + rep * (PLEN + g) + k;
          it.val     = int'(p[PLEN-1-k]);
          q.push_back(it);
        end
      d = a + r * PLEN + (r - 1) * g;
    end
    it.is_done = 1'b1;
    it.cyc     = d;
    it.val     = (r == 0) ? 0 : r * PLEN + (r - 1) * g;
    q.push_back(it);
    next_accept = d + 2;
  endfunction

  task automatic apply(bit st, logic [PLEN-1:0] p, int r, int g);
    bus.start   = st;
    bus.pattern = p;
    bus.reps    = 4'(r);
    bus.gap     = 2'(g);
    if (st && (cyc + 1) >= next_accept) accept(cyc + 1, p, r, g);
  endtask

  task automatic drive(bit st, logic [PLEN-1:0] p, int r, int g);
    @(negedge clk);
    apply(st, p, r, g);
  endtask

  // Idle cycles with scrambled request fields to show they are ignored once captured
  task automatic idle(int n);
    repeat (n) drive(1'b0, PLEN'($urandom), int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a bit or a done pulse
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        n_vec++;
        n_fail++;
        $display("FAIL missed_output: expected %s at cycle %0d, still absent at cycle %0d",
                 q[0].is_done ? "done" : "bit", q[0].cyc, cyc);
        mon_it = q.pop_front();
      end
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.valid === 1'b1) begin
        if (q.size() == 0) chk("spurious_valid", 1, 0);
        else begin
          mon_it = q.pop_front();
          chk("valid_kind", int'(mon_it.is_done), 0);
          chk("bit_cycle", cyc, mon_it.cyc);
          chk("y_bit", int'(bus.y), mon_it.val);
        end
      end else begin
        chk("y_when_invalid", int'(bus.y), 0);
      end
      if (bus.done === 1'b1) begin
        if (q.size() == 0) chk("spurious_done", 1, 0);
        else begin
          mon_it = q.pop_front();
          chk("done_kind", int'(mon_it.is_done), 1);
          chk("done_cycle", cyc, mon_it.cyc);
          chk("busy_cycles", busy_cnt, mon_it.val);
        end
        chk("busy_in_done", int'(bus.busy), 0);
        busy_cnt = 0;
      end
    end
  end

  initial begin
    bus.start   = 1'b0;
    bus.pattern = '0;
    bus.reps    = '0;
    bus.gap     = '0;
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_y", int'(bus.y), 0);
    chk("reset_valid", int'(bus.valid), 0);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_done", int'(bus.done), 0);

    // start coincident with the first edge after release; single 1101
    @(negedge clk);
    rst = 1'b0;
    next_accept = 0;
    apply(1'b1, 4'b1101, 1, 0);
    idle(8);

    // two contiguous repetitions, then two with a 2-cycle gap
    drive(1'b1, 4'b1101, 2, 0);
    idle(12);
    drive(1'b1, 4'b1101, 2, 2);
    idle(14);

    // zero repetitions: done only
    drive(1'b1, PLEN'($urandom), 0, 1);
    idle(3);

    // start re-applied during the 2nd bit is ignored
    drive(1'b1, 4'b1101, 1, 0);
    idle(1);
    drive(1'b1, 4'b0000, 1, 0);
    idle(8);

    // start held high: bursts back-to-back at minimum spacing
    repeat (30) drive(1'b1, PLEN'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
    idle(15);

    // asynchronous reset during the 3rd bit of a 3-repetition burst
    drive(1'b1, 4'b1101, 3, 1);
    idle(2);
    @(posedge clk);
    #2;
    rst = 1'b1;
    q.delete();
    busy_cnt = 0;
    #1;
    chk("abort_y", int'(bus.y), 0);
    chk("abort_valid", int'(bus.valid), 0);
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_done", int'(bus.done), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    next_accept = 0;
    apply(1'b0, '0, 0, 0);
    idle(3);
    drive(1'b1, 4'b1101, 3, 1);
    idle(20);

    // randomized traffic
    repeat (400)
      drive($urandom_range(0, 2) == 0, PLEN'($urandom), int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));

    for (int i = 0; i < 300 && q.size() > 0; i++) idle(1);
    idle(2);
    chk("drain_queue_empty", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
